// File: rtl/u_insn_seq_ctrl_pkg.sv
// Shared types for the U-type (LUI/AUIPC) multi-cycle sequencer.
package u_seq_pkg;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    FETCH   = 6'b000010,
    DECODE  = 6'b000100,
    EXEC    = 6'b001000,
    WB      = 6'b010000,
    ILLEGAL = 6'b100000
  } state_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    CLS_BAD   = 2'd0,
    CLS_LUI   = 2'd1,
    CLS_AUIPC = 2'd2
  } insn_cls_t;

  // A full 7-bit opcode match already implies ir[1:0] == 2'b11.
  function automatic insn_cls_t classify(input logic [31:0] ir, input logic lui_ok);
    insn_cls_t cls;
    cls = CLS_BAD;
    if (ir[6:0] == OPC_AUIPC)
      cls = CLS_AUIPC;
    else if ((ir[6:0] == OPC_LUI) && lui_ok)
      cls = CLS_LUI;
    return cls;
  endfunction

endpackage

// File: rtl/u_insn_seq_ctrl_imm_gen.sv
// U-type immediate generator: {ir[31:12], 12'b0} sign-extended to XLEN.
module u_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = XLEN'(signed'({ir[31:12], 12'h000}));
  end

endmodule

// File: rtl/u_insn_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for LUI and AUIPC.
module u_insn_seq_ctrl
  import u_seq_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FETCH_WAIT  = 1,
  parameter bit          SUPPORT_LUI = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic [31:0]     INSN,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            ir_we,
  output logic            rd_we,
  output logic            pc_we,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            pc_next_sel,
  output logic            pc_alu_sel,
  output logic            sub_sra,
  output logic            alu_a_sel,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] imm
);

  localparam logic [3:0] WAIT_INIT = 4'(FETCH_WAIT);

  state_t    state_q, state_d;
  logic [3:0] wait_q;
  logic [31:0] ir_q;
  insn_cls_t cls_q, cls_dec, cls_cur;
  logic      illegal_q;
  logic      accept;

  assign cls_dec = classify(ir_q, SUPPORT_LUI);
  assign accept  = start && ((state_q == IDLE) || (state_q == WB));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    rd_we   = 1'b0;
    pc_we   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
        if (wait_q == '0) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE:  state_d = (cls_dec == CLS_BAD) ? ILLEGAL : EXEC;
      EXEC:    state_d = WB;
      WB: begin
        rd_we   = (ir_q[11:7] != '0);
        pc_we   = 1'b1;
        done    = 1'b1;
        state_d = start ? FETCH : IDLE;
      end
      ILLEGAL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_q    <= '0;
      ir_q      <= '0;
      cls_q     <= CLS_BAD;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        wait_q    <= WAIT_INIT;
        illegal_q <= 1'b0;
      end else if ((state_q == FETCH) && (wait_q != '0)) begin
        wait_q <= wait_q - 4'd1;
      end
      if (ir_we) ir_q <= INSN;
      if (state_q == DECODE) begin
        cls_q <= cls_dec;
        if (cls_dec == CLS_BAD) illegal_q <= 1'b1;
      end
    end
  end

  // During DECODE the class register has not loaded yet, so steer from the live decode.
  assign cls_cur   = (state_q == DECODE) ? cls_dec : cls_q;
  assign alu_a_sel = (cls_cur == CLS_LUI);

  assign busy        = (state_q != IDLE);
  assign illegal     = illegal_q;
  assign rd_addr     = ir_q[11:7];
  assign mem_we      = 1'b0;
  assign addr_sel    = 1'b0;
  assign pc_next_sel = 1'b0;
  assign pc_alu_sel  = 1'b0;
  assign sub_sra     = 1'b0;

  u_imm_gen #(.XLEN(XLEN)) u_imm (
    .ir  (ir_q),
    .imm (imm)
  );

endmodule

// File: tb/tb_u_insn_seq_ctrl.sv
// Directed bench for u_insn_seq_ctrl: XLEN=32/FETCH_WAIT=1 and XLEN=64/FETCH_WAIT=0 instances.
module tb_u_insn_seq_ctrl;

  logic clk;
  int n_checks = 0;
  int n_pass   = 0;

  logic        rst_n_a, start_a;
  logic [31:0] insn_a;
  logic        busy_a, done_a, illegal_a, ir_we_a, rd_we_a, pc_we_a, mem_we_a;
  logic        addr_sel_a, pc_next_sel_a, pc_alu_sel_a, sub_sra_a, alu_a_sel_a;
  logic [4:0]  rd_addr_a;
  logic [31:0] imm_a;

  logic        rst_n_b, start_b;
  logic [31:0] insn_b;
  logic        busy_b, done_b, illegal_b, ir_we_b, rd_we_b, pc_we_b, mem_we_b;
  logic        addr_sel_b, pc_next_sel_b, pc_alu_sel_b, sub_sra_b, alu_a_sel_b;
  logic [4:0]  rd_addr_b;
  logic [63:0] imm_b;

  u_insn_seq_ctrl #(.XLEN(32), .FETCH_WAIT(1), .SUPPORT_LUI(1'b1)) dut_a (
    .CLK(clk), .RST_N(rst_n_a), .start(start_a), .INSN(insn_a),
    .busy(busy_a), .done(done_a), .illegal(illegal_a), .ir_we(ir_we_a),
    .rd_we(rd_we_a), .pc_we(pc_we_a), .mem_we(mem_we_a), .addr_sel(addr_sel_a),
    .pc_next_sel(pc_next_sel_a), .pc_alu_sel(pc_alu_sel_a), .sub_sra(sub_sra_a),
    .alu_a_sel(alu_a_sel_a), .rd_addr(rd_addr_a), .imm(imm_a)
  );

  u_insn_seq_ctrl #(.XLEN(64), .FETCH_WAIT(0), .SUPPORT_LUI(1'b1)) dut_b (
    .CLK(clk), .RST_N(rst_n_b), .start(start_b), .INSN(insn_b),
    .busy(busy_b), .done(done_b), .illegal(illegal_b), .ir_we(ir_we_b),
    .rd_we(rd_we_b), .pc_we(pc_we_b), .mem_we(mem_we_b), .addr_sel(addr_sel_b),
    .pc_next_sel(pc_next_sel_b), .pc_alu_sel(pc_alu_sel_b), .sub_sra(sub_sra_b),
    .alu_a_sel(alu_a_sel_b), .rd_addr(rd_addr_b), .imm(imm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] done_pat, busy_pat, ir_we_pat;
  logic       seen;

  initial begin
    rst_n_a = 1'b0; start_a = 1'b0; insn_a = '0;
    rst_n_b = 1'b0; start_b = 1'b0; insn_b = '0;
    tick(); tick();
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_outs_a", 64'({done_a, illegal_a, ir_we_a, rd_we_a, pc_we_a, alu_a_sel_a}), 64'd0);
    check("rst_imm_b", imm_b, 64'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();

    // AUIPC x5 on the FETCH_WAIT=1 instance
    insn_a = 32'h12345297; start_a = 1'b1;
    tick(); start_a = 1'b0;
    check("auipc_fetch1_busy", 64'(busy_a), 64'd1);
    check("auipc_fetch1_ir_we", 64'(ir_we_a), 64'd0);
    check("auipc_fetch_addr_sel", 64'(addr_sel_a), 64'd0);
    tick();
    check("auipc_fetch2_ir_we", 64'(ir_we_a), 64'd1);
    tick();
    check("auipc_decode_imm", 64'(imm_a), 64'h12345000);
    check("auipc_decode_ir_we", 64'(ir_we_a), 64'd0);
    tick();
    start_a = 1'b1;  // pulse during EXEC must be ignored
    check("auipc_exec_enables", 64'({rd_we_a, pc_we_a, done_a}), 64'd0);
    tick(); start_a = 1'b0;
    check("auipc_wb_enables", 64'({rd_we_a, pc_we_a, done_a}), 64'b111);
    check("auipc_wb_rd_addr", 64'(rd_addr_a), 64'd5);
    check("auipc_wb_imm", 64'(imm_a), 64'h12345000);
    check("auipc_wb_alu_a_sel", 64'(alu_a_sel_a), 64'd0);
    check("auipc_wb_zero_outs", 64'({mem_we_a, pc_next_sel_a, pc_alu_sel_a, sub_sra_a, illegal_a}), 64'd0);
    tick();
    check("auipc_idle_busy", 64'(busy_a), 64'd0);
    check("auipc_idle_imm_hold", 64'(imm_a), 64'h12345000);

    // Illegal (addi) then a clearing start
    insn_a = 32'h00000013; start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick();
    check("ill_decode_flag", 64'(illegal_a), 64'd0);
    tick();
    check("ill_state_flag", 64'(illegal_a), 64'd1);
    check("ill_state_enables", 64'({rd_we_a, pc_we_a, done_a}), 64'd0);
    check("ill_state_busy", 64'(busy_a), 64'd1);
    tick();
    check("ill_idle_sticky", 64'(illegal_a), 64'd1);
    check("ill_idle_busy", 64'(busy_a), 64'd0);
    insn_a = 32'h12345297; start_a = 1'b1;
    tick(); start_a = 1'b0;
    check("ill_cleared_on_start", 64'(illegal_a), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (done_a) seen = 1'b1;
    end
    check("ill_followup_done", 64'(seen), 64'd1);
    tick();

    // LUI x0: write suppressed, PC still advances
    insn_a = 32'h00001037; start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick(); tick(); tick();
    check("x0_wb_enables", 64'({rd_we_a, pc_we_a, done_a}), 64'b011);
    check("x0_wb_alu_a_sel", 64'(alu_a_sel_a), 64'd1);
    check("x0_wb_imm", 64'(imm_a), 64'h00001000);
    tick();

    // Reset asserted mid-FETCH
    insn_a = 32'h12345297; start_a = 1'b1;
    tick(); start_a = 1'b0;
    check("midrst_pre_alu_a_sel", 64'(alu_a_sel_a), 64'd1);
    rst_n_a = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_outs", 64'({alu_a_sel_a, ir_we_a, rd_we_a, pc_we_a, done_a, illegal_a}), 64'd0);
    check("midrst_imm", 64'(imm_a), 64'd0);
    tick(); tick();
    rst_n_a = 1'b1;
    tick();
    check("midrst_after_busy", 64'(busy_a), 64'd0);
    check("midrst_after_enables", 64'({ir_we_a, rd_we_a, pc_we_a, done_a}), 64'd0);

    // LUI x1 on XLEN=64, FETCH_WAIT=0
    insn_b = 32'h800000B7; start_b = 1'b1;
    tick(); start_b = 1'b0;
    check("lui64_fetch_ir_we", 64'(ir_we_b), 64'd1);
    tick();
    check("lui64_decode_alu_a_sel", 64'(alu_a_sel_b), 64'd1);
    check("lui64_decode_imm", imm_b, 64'hFFFFFFFF80000000);
    tick(); tick();
    check("lui64_wb_enables", 64'({rd_we_b, pc_we_b, done_b}), 64'b111);
    check("lui64_wb_rd_addr", 64'(rd_addr_b), 64'd1);
    tick();

    // Back-to-back with start held: WB every 4 cycles, never idle
    insn_b = 32'h12345297; start_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      done_pat[c-1]  = done_b;
      busy_pat[c-1]  = busy_b;
      ir_we_pat[c-1] = ir_we_b;
    end
    start_b = 1'b0;
    check("b2b_done_pattern", 64'(done_pat), 64'(8'b1000_1000));
    check("b2b_busy_pattern", 64'(busy_pat), 64'(8'hFF));
    check("b2b_ir_we_pattern", 64'(ir_we_pat), 64'(8'b0001_0001));
    check("b2b_imm", imm_b, 64'h0000000012345000);
    tick();
    check("b2b_idle_busy", 64'(busy_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
